mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle MIPS datapath (PC, IR, register file, ALU, unified memory) in place of the single-cycle opcode decoder.
- Issues per-state control strobes, waits on a memory ready handshake, flags illegal opcodes and counts retired instructions.
- Sits beside the datapath top level and drives every datapath mux and write enable.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready before a mem_timeout abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access
- mem_req  out  1  memory access request
- mem_read  out  1  read access
- mem_write  out  1  write access
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- alu_op  out  3  000 R-type (funct decode), 001 add, 010 sub, 011 slt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse on a handshake timeout
- instr_count  out  CNT_W  retired instructions
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - rst_n low → state IDLE, instr_count 0, wait counter 0.
  - All outputs are 0 in IDLE.
  - IDLE → FETCH unconditionally on the next edge after rst_n deasserts.
- Opcodes:
  - R = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000, SLTI = 001010, J = 000010.
- States, transitions and asserted outputs (outputs not listed are 0):
  - FETCH: mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=001. ir_write and pc_write are asserted only in the cycle mem_ready=1. Stay while mem_ready=0; go to DECODE on mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=001 (branch target into ALUOut). Next state by op: LW/SW → MEM_ADR; R → EXEC_R; BEQ → BRANCH; ADDI/SLTI → EXEC_I; J → JUMP; any other op → FETCH with illegal_op=1.
  - MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=001. LW → MEM_RD; SW → MEM_WR.
  - MEM_RD: mem_req, mem_read, iord=1. Wait for mem_ready, then → MEM_WB.
  - MEM_WB: reg_write, mem_to_reg=1, reg_dst=0 → FETCH (retire).
  - MEM_WR: mem_req, mem_write, iord=1. Wait for mem_ready, then → FETCH (retire).
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=000 → ALU_WB_R.
  - ALU_WB_R: reg_write, reg_dst=1, mem_to_reg=0 → FETCH (retire).
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=001 for ADDI, 011 for SLTI → ALU_WB_I.
  - ALU_WB_I: reg_write, reg_dst=0 → FETCH (retire).
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond, pc_source=01 → FETCH (retire).
  - JUMP: pc_write, pc_source=10 → FETCH (retire).
- Retire: instr_count increments by 1 on the transition into FETCH from any retiring state. It wraps modulo 2^CNT_W. Illegal opcodes and timeouts do not retire.
- Handshake:
  - mem_req, mem_read and mem_write are held constant while waiting.
  - A mem_ready that arrives in the same cycle as mem_req completes the access (zero wait states).
  - mem_ready outside FETCH, MEM_RD or MEM_WR is ignored.
- Timeout:
  - The wait counter clears on entry to each memory state and increments every waiting cycle.
  - When the counter reaches TIMEOUT with mem_ready still 0, the next state is FETCH, mem_timeout pulses for one cycle, and no write enable is asserted.
- Outputs are combinational from the state (plus mem_ready and op where stated above); no latches.
- Asynchronous reset mid-access drops every strobe immediately.

Decomposition:
- Package mips_pkg holds:
  - opcode constants;
  - the alu_op encodings;
  - the pc_source and alu_src_b encodings;
  - the state enumeration (4-bit).
- One natural sub-module, mips_wait_timer: the wait counter with clear, enable and expired output.

Test Plan:
- Reset: rst_n low for 3 cycles → all outputs 0 and state=IDLE; release → one cycle of IDLE, then FETCH with mem_req=1.
- ADDI with mem_ready held 1 → FETCH, DECODE, EXEC_I (alu_op=001), ALU_WB_I (reg_write=1, reg_dst=0); instr_count 0→1; 4 cycles total.
- LW with 3 wait cycles on MEM_RD → mem_read/iord stay 1 for 4 cycles; MEM_WB asserts mem_to_reg=1; instr_count +1.
- BEQ with zero=1 → BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=010; J → pc_source=10, pc_write=1.
- op=111111 → illegal_op pulses for one cycle in DECODE, return to FETCH, instr_count unchanged.
- TIMEOUT=4 and mem_ready stuck at 0 in MEM_WR → mem_timeout pulses after 4 wait cycles, mem_write drops, state returns to FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Opcodes, datapath mux selects and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    ALU_RTYPE = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_SLT   = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADR  = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_ALU_WB_R = 4'd8,
    S_EXEC_I   = 4'd9,
    S_ALU_WB_I = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Memory handshake wait counter.
// Expires when the count reaches TIMEOUT; TIMEOUT=0 never expires.
module mips_wait_timer
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (TIMEOUT != 0) && (cnt_q == W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: per-state strobes, memory
// handshake with timeout, illegal-op flag and retire counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic in_mem;
  logic expired;
  logic retire;
  logic zero_unused;

  // zero is consumed by the datapath PC-enable gate, not here
  assign zero_unused = zero;

  assign in_mem = is_mem_state(state_q);

  mips_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!in_mem || mem_ready || expired),
    .en_i     (in_mem && !mem_ready),
    .expired_o(expired)
  );

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_RTYPE;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):   state_d = S_MEM_ADR;
          (op == OP_R):    state_d = S_EXEC_R;
          (op == OP_BEQ):  state_d = S_BRANCH;
          (op == OP_ADDI),
          (op == OP_SLTI): state_d = S_EXEC_I;
          (op == OP_J):    state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (expired) begin
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = ALU_RTYPE;
        state_d   = S_ALU_WB_R;
      end

      S_ALU_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_ALU_WB_I;
      end

      S_ALU_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// Per-cycle expectations are queued by the tests and checked at negedge.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI = 6'b001010;
  localparam logic [5:0] T_J    = 6'b000010;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(
    .CNT_W  (CNT_W),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .instr_count  (instr_count),
    .state        (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       rd;
    logic       wr;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ill;
    logic       to;
  } ctl_t;

  typedef struct packed {
    ctl_t             e;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  ctl_t obs;
  assign obs = {state, mem_req, mem_read, mem_write, iord, ir_write,
                pc_write, pc_write_cond, pc_source, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, illegal_op,
                mem_timeout};

  exp_t             sb[$];
  int               n_tests = 0;
  int               n_fail = 0;
  string            cur = "none";
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic ctl_t mk(int st, int req, int rd, int wr, int io,
                              int irw, int pcw, int pcwc, int pcs,
                              int rdst, int m2r, int rw, int asa,
                              int asb, int aop, int ill, int to);
    return {4'(st), 1'(req), 1'(rd), 1'(wr), 1'(io), 1'(irw), 1'(pcw),
            1'(pcwc), 2'(pcs), 1'(rdst), 1'(m2r), 1'(rw), 1'(asa),
            2'(asb), 3'(aop), 1'(ill), 1'(to)};
  endfunction

  ctl_t E_IDLE, E_FW, E_FR, E_FTO, E_DEC, E_DILL, E_MADR, E_MRD;
  ctl_t E_MWB, E_MWR, E_MWTO, E_EXR, E_WBR, E_EXA, E_EXS, E_WBI;
  ctl_t E_BR, E_J;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t r;
      r = sb.pop_front();
      n_tests++;
      if (obs !== r.e) begin
        n_fail++;
        $display("FAIL %s ctl: got %h want %h (state %0d want %0d)",
                 cur, obs, r.e, obs.st, r.e.st);
      end
      n_tests++;
      if (instr_count !== r.cnt) begin
        n_fail++;
        $display("FAIL %s count: got %0d want %0d",
                 cur, instr_count, r.cnt);
      end
    end
  end

  task automatic step(ctl_t e, logic rdy, logic [5:0] o);
    exp_t x;
    mem_ready = rdy;
    op        = o;
    x.e       = e;
    x.cnt     = exp_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cur       = "reset";
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (state !== 4'd0 || mem_req !== 1'b0 || instr_count !== '0) begin
      n_fail++;
      $display("FAIL reset_inline: got state %0d req %b cnt %0d want 0 0 0",
               state, mem_req, instr_count);
    end
    repeat (3) step(E_IDLE, 1'b1, T_LW);
    rst_n = 1'b1;
    step(E_IDLE, 1'b0, T_LW);
    step(E_FW, 1'b0, T_LW);
  endtask

  task automatic test_addi();
    cur = "addi";
    step(E_FR, 1'b1, T_ADDI);
    step(E_DEC, 1'b1, T_ADDI);
    step(E_EXA, 1'b1, T_ADDI);
    step(E_WBI, 1'b1, T_ADDI);
    exp_cnt = exp_cnt + 1'b1;
    step(E_FW, 1'b0, T_ADDI);
  endtask

  task automatic test_lw_wait();
    cur = "lw_wait";
    step(E_FR, 1'b1, T_LW);
    step(E_DEC, 1'b0, T_LW);
    step(E_MADR, 1'b1, T_LW);
    repeat (3) step(E_MRD, 1'b0, T_LW);
    step(E_MRD, 1'b1, T_LW);
    step(E_MWB, 1'b0, T_LW);
    exp_cnt = exp_cnt + 1'b1;
    step(E_FW, 1'b0, T_LW);
  endtask

  task automatic test_sw_zero_wait();
    cur = "sw_zero_wait";
    step(E_FR, 1'b1, T_SW);
    step(E_DEC, 1'b1, T_SW);
    step(E_MADR, 1'b1, T_SW);
    step(E_MWR, 1'b1, T_SW);
    exp_cnt = exp_cnt + 1'b1;
    step(E_FW, 1'b0, T_SW);
  endtask

  task automatic test_rtype_slti();
    cur = "rtype";
    step(E_FR, 1'b1, T_R);
    step(E_DEC, 1'b1, T_R);
    step(E_EXR, 1'b1, T_R);
    step(E_WBR, 1'b1, T_R);
    exp_cnt = exp_cnt + 1'b1;
    cur = "slti";
    step(E_FR, 1'b1, T_SLTI);
    step(E_DEC, 1'b1, T_SLTI);
    step(E_EXS, 1'b1, T_SLTI);
    step(E_WBI, 1'b1, T_SLTI);
    exp_cnt = exp_cnt + 1'b1;
    step(E_FW, 1'b0, T_SLTI);
  endtask

  task automatic test_branch_jump();
    cur  = "beq";
    zero = 1'b1;
    step(E_FR, 1'b1, T_BEQ);
    step(E_DEC, 1'b1, T_BEQ);
    step(E_BR, 1'b1, T_BEQ);
    exp_cnt = exp_cnt + 1'b1;
    zero = 1'b0;
    cur  = "jump";
    step(E_FR, 1'b1, T_J);
    step(E_DEC, 1'b1, T_J);
    step(E_J, 1'b1, T_J);
    exp_cnt = exp_cnt + 1'b1;
    step(E_FW, 1'b0, T_J);
  endtask

  task automatic test_illegal();
    cur = "illegal_3f";
    step(E_FR, 1'b1, 6'h3f);
    step(E_DILL, 1'b1, 6'h3f);
    step(E_FW, 1'b0, 6'h3f);
    cur = "illegal_01";
    step(E_FR, 1'b1, 6'h01);
    step(E_DILL, 1'b1, 6'h01);
    step(E_FW, 1'b0, 6'h01);
  endtask

  // Entered with FETCH having already waited one cycle.
  task automatic test_fetch_timeout();
    cur = "fetch_timeout";
    repeat (3) step(E_FW, 1'b0, T_J);
    step(E_FTO, 1'b0, T_J);
    step(E_FW, 1'b0, T_J);
  endtask

  task automatic test_sw_timeout();
    cur = "sw_timeout";
    step(E_FR, 1'b1, T_SW);
    step(E_DEC, 1'b1, T_SW);
    step(E_MADR, 1'b1, T_SW);
    repeat (4) step(E_MWR, 1'b0, T_SW);
    step(E_MWTO, 1'b0, T_SW);
    step(E_FW, 1'b0, T_SW);
  endtask

  task automatic test_back_to_back();
    cur = "back_to_back";
    for (int i = 0; i < 12; i++) begin
      step(E_FR, 1'b1, T_J);
      step(E_DEC, 1'b1, T_J);
      step(E_J, 1'b1, T_J);
      exp_cnt = exp_cnt + 1'b1;
    end
    step(E_FW, 1'b0, T_J);
  endtask

  task automatic test_async_reset();
    cur = "async_reset";
    step(E_FR, 1'b1, T_LW);
    step(E_DEC, 1'b1, T_LW);
    step(E_MADR, 1'b1, T_LW);
    step(E_MRD, 1'b0, T_LW);
    #2;
    n_tests++;
    if (mem_req !== 1'b1 || state !== 4'd4) begin
      n_fail++;
      $display("FAIL async_pre: got req %b state %0d want 1 4",
               mem_req, state);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== E_IDLE || instr_count !== '0) begin
      n_fail++;
      $display("FAIL async_drop: got %h cnt %0d want %h cnt 0",
               obs, instr_count, E_IDLE);
    end
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(E_IDLE, 1'b0, T_LW);
    step(E_FW, 1'b0, T_LW);
  endtask

  initial begin
    E_IDLE = mk(0, 0,0,0,0, 0,0,0, 0, 0,0,0, 0, 0, 0, 0,0);
    E_FW   = mk(1, 1,1,0,0, 0,0,0, 0, 0,0,0, 0, 1, 1, 0,0);
    E_FR   = mk(1, 1,1,0,0, 1,1,0, 0, 0,0,0, 0, 1, 1, 0,0);
    E_FTO  = mk(1, 1,1,0,0, 0,0,0, 0, 0,0,0, 0, 1, 1, 0,1);
    E_DEC  = mk(2, 0,0,0,0, 0,0,0, 0, 0,0,0, 0, 3, 1, 0,0);
    E_DILL = mk(2, 0,0,0,0, 0,0,0, 0, 0,0,0, 0, 3, 1, 1,0);
    E_MADR = mk(3, 0,0,0,0, 0,0,0, 0, 0,0,0, 1, 2, 1, 0,0);
    E_MRD  = mk(4, 1,1,0,1, 0,0,0, 0, 0,0,0, 0, 0, 0, 0,0);
    E_MWB  = mk(5, 0,0,0,0, 0,0,0, 0, 0,1,1, 0, 0, 0, 0,0);
    E_MWR  = mk(6, 1,0,1,1, 0,0,0, 0, 0,0,0, 0, 0, 0, 0,0);
    E_MWTO = mk(6, 1,0,1,1, 0,0,0, 0, 0,0,0, 0, 0, 0, 0,1);
    E_EXR  = mk(7, 0,0,0,0, 0,0,0, 0, 0,0,0, 1, 0, 0, 0,0);
    E_WBR  = mk(8, 0,0,0,0, 0,0,0, 0, 1,0,1, 0, 0, 0, 0,0);
    E_EXA  = mk(9, 0,0,0,0, 0,0,0, 0, 0,0,0, 1, 2, 1, 0,0);
    E_EXS  = mk(9, 0,0,0,0, 0,0,0, 0, 0,0,0, 1, 2, 3, 0,0);
    E_WBI  = mk(10,0,0,0,0, 0,0,0, 0, 0,0,1, 0, 0, 0, 0,0);
    E_BR   = mk(11,0,0,0,0, 0,0,1, 1, 0,0,0, 1, 0, 2, 0,0);
    E_J    = mk(12,0,0,0,0, 0,1,0, 2, 0,0,0, 0, 0, 0, 0,0);

    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_zero_wait();
    test_rtype_slti();
    test_branch_jump();
    test_illegal();
    test_fetch_timeout();
    test_sw_timeout();
    test_back_to_back();
    test_async_reset();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
